// File: rtl/apb_reg_init_seq.sv
// Walks a register-init table and writes each entry over APB, optionally reading
// it back to confirm; reports busy/done/stopped and the first failing entry.
`timescale 1ns/1ps
module apb_reg_init_seq #(
  parameter int NO_APB_REGS = 342,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 16,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0013_0000,
  parameter int ADDR_STRIDE = 4,
  localparam int IDX_W = $clog2(NO_APB_REGS)
) (
  input  logic                        p_clk,
  input  logic                        p_rst,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic                        verify_en_i,
  output logic                        tbl_rd_o,
  output logic [IDX_W-1:0]            tbl_idx_o,
  input  logic [REG_DATA_WIDTH-1:0]   tbl_data_i,
  output logic [APB_ADDR_WIDTH-1:0]   apb_reg_paddr,
  output logic [2:0]                  apb_reg_pprot,
  output logic                        apb_reg_psel,
  output logic                        apb_reg_penable,
  output logic                        apb_reg_pwrite,
  output logic [APB_DATA_WIDTH-1:0]   apb_reg_pwdata,
  output logic [APB_DATA_WIDTH/8-1:0] apb_reg_pstrb,
  input  logic                        apb_reg_pready,
  input  logic [APB_DATA_WIDTH-1:0]   apb_reg_prdata,
  input  logic                        apb_reg_pslverr,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        stopped_o,
  output logic                        err_o,
  output logic [IDX_W-1:0]            err_idx_o
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WR_SETUP, WR_ACCESS, RB_SETUP, RB_ACCESS, DONE
  } state_t;

  state_t                    state, next_state;
  logic [IDX_W-1:0]          idx;
  logic [REG_DATA_WIDTH-1:0] data_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      verify_q;
  logic                      stop_pend;
  logic                      err_q;
  logic [IDX_W-1:0]          err_idx_q;
  logic                      stopped_q;

  logic                      last_entry;
  logic                      stop_req;
  logic                      entry_end;
  logic                      entry_err;
  logic                      rb_mismatch;
  logic [REG_DATA_WIDTH-1:0] cur_data;
  logic                      unused_prdata_hi;

  assign last_entry  = (idx == IDX_W'(NO_APB_REGS - 1));
  assign stop_req    = stop_pend | stop_i;
  assign rb_mismatch = (apb_reg_prdata[REG_DATA_WIDTH-1:0] != data_q);
  assign entry_end   = apb_reg_pready &
                       (((state == WR_ACCESS) && !verify_q) || (state == RB_ACCESS));
  assign entry_err   = apb_reg_pready &
                       (((state == WR_ACCESS) && apb_reg_pslverr) ||
                        ((state == RB_ACCESS) && (apb_reg_pslverr || rb_mismatch)));
  // Table data arrives during WR_SETUP itself, so it is forwarded there and held afterwards.
  assign cur_data    = (state == WR_SETUP) ? tbl_data_i : data_q;
  assign unused_prdata_hi = ^apb_reg_prdata[APB_DATA_WIDTH-1:REG_DATA_WIDTH];

  always_ff @(posedge p_clk) begin
    if (p_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start_i) next_state = FETCH;
      FETCH:     next_state = WR_SETUP;
      WR_SETUP:  next_state = WR_ACCESS;
      WR_ACCESS: if (apb_reg_pready) begin
                   if (verify_q)                  next_state = RB_SETUP;
                   else if (last_entry || stop_req) next_state = DONE;
                   else                           next_state = FETCH;
                 end
      RB_SETUP:  next_state = RB_ACCESS;
      RB_ACCESS: if (apb_reg_pready) next_state = (last_entry || stop_req) ? DONE : FETCH;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (p_rst) begin
      idx       <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      verify_q  <= 1'b0;
      stop_pend <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      stopped_q <= 1'b0;
    end else begin
      if (state == IDLE && start_i) begin
        idx       <= '0;
        verify_q  <= verify_en_i;
        err_q     <= 1'b0;
        err_idx_q <= '0;
        stopped_q <= 1'b0;
        stop_pend <= 1'b0;
      end
      if (state != IDLE && stop_i) stop_pend <= 1'b1;
      if (state == FETCH)
        addr_q <= BASE_ADDR + APB_ADDR_WIDTH'(idx) * APB_ADDR_WIDTH'(ADDR_STRIDE);
      if (state == WR_SETUP) data_q <= tbl_data_i;
      if (entry_err) begin
        err_q <= 1'b1;
        if (!err_q) err_idx_q <= idx;
      end
      if (entry_end && !(last_entry || stop_req)) idx <= idx + IDX_W'(1);
      if (entry_end && stop_req) stopped_q <= 1'b1;
      if (state == DONE) stop_pend <= 1'b0;
    end
  end

  always_comb begin
    tbl_rd_o        = 1'b0;
    apb_reg_psel    = 1'b0;
    apb_reg_penable = 1'b0;
    apb_reg_pwrite  = 1'b0;
    apb_reg_pstrb   = '0;
    case (state)
      FETCH:     tbl_rd_o = 1'b1;
      WR_SETUP:  begin
                   apb_reg_psel   = 1'b1;
                   apb_reg_pwrite = 1'b1;
                   apb_reg_pstrb  = '1;
                 end
      WR_ACCESS: begin
                   apb_reg_psel    = 1'b1;
                   apb_reg_penable = 1'b1;
                   apb_reg_pwrite  = 1'b1;
                   apb_reg_pstrb   = '1;
                 end
      RB_SETUP:  apb_reg_psel = 1'b1;
      RB_ACCESS: begin
                   apb_reg_psel    = 1'b1;
                   apb_reg_penable = 1'b1;
                 end
      default:   ;
    endcase
  end

  assign tbl_idx_o      = idx;
  assign apb_reg_paddr  = addr_q;
  assign apb_reg_pwdata = APB_DATA_WIDTH'(cur_data);
  assign apb_reg_pprot  = 3'b000;
  assign busy_o         = (state != IDLE);
  assign done_o         = (state == DONE);
  assign stopped_o      = stopped_q;
  assign err_o          = err_q;
  assign err_idx_o      = err_idx_q;

endmodule

// File: tb/tb_apb_reg_init_seq.sv
// Scoreboard bench for apb_reg_init_seq: expected APB transfers and completion
// status are queued with each sequence start and checked by an independent monitor.
`timescale 1ns/1ps
module tb_apb_reg_init_seq;

  localparam int N = 342;
  localparam logic [31:0] BASE = 32'h0013_0000;

  logic        p_clk = 1'b0;
  logic        p_rst = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        verify_en_i = 1'b0;
  logic        tbl_rd_o;
  logic [8:0]  tbl_idx_o;
  logic [15:0] tbl_data_i = 16'h0;
  logic [31:0] apb_reg_paddr;
  logic [2:0]  apb_reg_pprot;
  logic        apb_reg_psel;
  logic        apb_reg_penable;
  logic        apb_reg_pwrite;
  logic [31:0] apb_reg_pwdata;
  logic [3:0]  apb_reg_pstrb;
  logic        apb_reg_pready;
  logic [31:0] apb_reg_prdata;
  logic        apb_reg_pslverr;
  logic        busy_o, done_o, stopped_o, err_o;
  logic [8:0]  err_idx_o;

  apb_reg_init_seq dut (
    .p_clk(p_clk), .p_rst(p_rst), .start_i(start_i), .stop_i(stop_i),
    .verify_en_i(verify_en_i), .tbl_rd_o(tbl_rd_o), .tbl_idx_o(tbl_idx_o),
    .tbl_data_i(tbl_data_i), .apb_reg_paddr(apb_reg_paddr),
    .apb_reg_pprot(apb_reg_pprot), .apb_reg_psel(apb_reg_psel),
    .apb_reg_penable(apb_reg_penable), .apb_reg_pwrite(apb_reg_pwrite),
    .apb_reg_pwdata(apb_reg_pwdata), .apb_reg_pstrb(apb_reg_pstrb),
    .apb_reg_pready(apb_reg_pready), .apb_reg_prdata(apb_reg_prdata),
    .apb_reg_pslverr(apb_reg_pslverr), .busy_o(busy_o), .done_o(done_o),
    .stopped_o(stopped_o), .err_o(err_o), .err_idx_o(err_idx_o)
  );

  always #5 p_clk = ~p_clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } txn_t;

  typedef struct {
    logic       err;
    logic [8:0] eidx;
    logic       stopped;
    int         lat;
  } done_t;

  txn_t  exp_q[$];
  done_t done_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string cur_test = "reset";

  logic [15:0] tbl_mem [N];
  logic [31:0] slv_mem [N];
  logic        slverr_mask [N];
  int          rb_bad = -1;
  int          wait_cfg = 0;
  int          wait_left = 0;
  int          cyc = 0;
  int          fetch0 = 0;
  bit          fetch_pend = 1'b0;
  logic [31:0] slv_off;
  logic        in_rng;

  // Slave model: stores writes, returns low half of stored data with junk upper bits.
  always_comb begin
    slv_off         = (apb_reg_paddr - BASE) >> 2;
    in_rng          = (slv_off < 32'(N));
    apb_reg_pready  = (wait_left == 0);
    apb_reg_prdata  = 32'h0;
    apb_reg_pslverr = 1'b0;
    if (in_rng) begin
      apb_reg_prdata  = (int'(slv_off) == rb_bad) ? 32'h0000_FFFF
                                                  : {16'hA5A5, slv_mem[slv_off[8:0]][15:0]};
      apb_reg_pslverr = apb_reg_psel & apb_reg_penable & apb_reg_pready &
                        apb_reg_pwrite & slverr_mask[slv_off[8:0]];
    end
  end

  always @(posedge p_clk) begin
    if (tbl_rd_o) tbl_data_i <= tbl_mem[tbl_idx_o];
    if (apb_reg_psel && !apb_reg_penable) wait_left <= wait_cfg;
    else if (apb_reg_psel && apb_reg_penable && wait_left != 0) wait_left <= wait_left - 1;
    if (apb_reg_psel && apb_reg_penable && apb_reg_pready && apb_reg_pwrite && in_rng)
      slv_mem[slv_off[8:0]] <= apb_reg_pwdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h at %0t", cur_test, name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation for every completed APB transfer and every done pulse.
  always @(negedge p_clk) begin
    txn_t  e;
    done_t d;
    cyc++;
    if (fetch_pend && tbl_rd_o) begin
      fetch0     = cyc;
      fetch_pend = 1'b0;
    end
    if (apb_reg_psel && apb_reg_penable && apb_reg_pready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected transfer paddr", apb_reg_paddr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("paddr", apb_reg_paddr, e.addr);
        checkOutput("pwrite", 32'(apb_reg_pwrite), 32'(e.wr));
        checkOutput("pstrb", 32'(apb_reg_pstrb), e.wr ? 32'hF : 32'h0);
        checkOutput("pprot", 32'(apb_reg_pprot), 32'h0);
        if (e.wr) checkOutput("pwdata", apb_reg_pwdata, e.wdata);
      end
    end
    if (done_o) begin
      if (done_q.size() == 0) begin
        checkOutput("unexpected done_o", 32'(done_o), 32'h0);
      end else begin
        d = done_q.pop_front();
        checkOutput("err_o", 32'(err_o), 32'(d.err));
        checkOutput("err_idx_o", 32'(err_idx_o), 32'(d.eidx));
        checkOutput("stopped_o", 32'(stopped_o), 32'(d.stopped));
        checkOutput("done latency", 32'(cyc - fetch0), 32'(d.lat));
      end
    end
  end

  task automatic fill_table(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       tbl_mem[i] = 16'(i);
        1:       tbl_mem[i] = 16'(i * 3 + 16'h0100);
        default: tbl_mem[i] = ~16'(i);
      endcase
      slverr_mask[i] = 1'b0;
    end
    rb_bad = -1;
  endtask

  task automatic push_entries(input int count, input bit verify);
    txn_t t;
    for (int i = 0; i < count; i++) begin
      t.addr  = BASE + 32'(i) * 32'd4;
      t.wdata = {16'h0, tbl_mem[i]};
      t.wr    = 1'b1;
      exp_q.push_back(t);
      if (verify) begin
        t.wdata = 32'h0;
        t.wr    = 1'b0;
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic push_done(input logic err, input logic [8:0] eidx, input logic stopped, input int lat);
    done_t d;
    d.err = err; d.eidx = eidx; d.stopped = stopped; d.lat = lat;
    done_q.push_back(d);
  endtask

  task automatic applyStimulus(input bit verify);
    @(negedge p_clk);
    verify_en_i = verify;
    start_i     = 1'b1;
    fetch_pend  = 1'b1;
    @(negedge p_clk);
    start_i     = 1'b0;
    verify_en_i = 1'b0;
  endtask

  task automatic wait_access(input int i, input int max);
    int k = 0;
    while (!(apb_reg_psel && apb_reg_penable && apb_reg_paddr == BASE + 32'(i) * 32'd4) && k < max) begin
      @(negedge p_clk);
      k++;
    end
    if (k >= max) checkOutput("timeout waiting for access", 32'(k), 32'(i));
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (!done_o && k < max) begin
      @(negedge p_clk);
      k++;
    end
    if (k >= max) begin
      checkOutput("timeout waiting for done_o", 32'(k), 32'(max));
      exp_q.delete();
      done_q.delete();
    end else begin
      @(negedge p_clk);
      checkOutput("done_o single cycle", 32'(done_o), 32'h0);
      checkOutput("busy_o after done", 32'(busy_o), 32'h0);
      checkOutput("transfers left over", 32'(exp_q.size()), 32'h0);
      checkOutput("done records left over", 32'(done_q.size()), 32'h0);
    end
  endtask

  initial begin
    repeat (3) @(negedge p_clk);
    checkOutput("reset busy_o", 32'(busy_o), 32'h0);
    checkOutput("reset psel", 32'(apb_reg_psel), 32'h0);
    checkOutput("reset penable", 32'(apb_reg_penable), 32'h0);
    checkOutput("reset tbl_rd_o", 32'(tbl_rd_o), 32'h0);
    checkOutput("reset done_o", 32'(done_o), 32'h0);
    checkOutput("reset err_o", 32'(err_o), 32'h0);
    checkOutput("reset stopped_o", 32'(stopped_o), 32'h0);
    checkOutput("reset paddr", apb_reg_paddr, 32'h0);
    p_rst = 1'b0;

    cur_test = "full_write";
    fill_table(0);
    push_entries(N, 1'b0);
    push_done(1'b0, 9'd0, 1'b0, 1026);
    applyStimulus(1'b0);
    wait_done(3000);
    checkOutput("last entry stored", slv_mem[341], 32'd341);

    cur_test = "verify_bad_rb5";
    fill_table(1);
    rb_bad = 5;
    push_entries(N, 1'b1);
    push_done(1'b1, 9'd5, 1'b0, 1710);
    applyStimulus(1'b1);
    wait_done(4000);
    rb_bad = -1;
    checkOutput("last entry stored", slv_mem[341], 32'h0000_04FF);

    cur_test = "slverr_7_9";
    fill_table(2);
    slverr_mask[7] = 1'b1;
    slverr_mask[9] = 1'b1;
    push_entries(N, 1'b0);
    push_done(1'b1, 9'd7, 1'b0, 1026);
    applyStimulus(1'b0);
    wait_done(3000);

    cur_test = "stop_entry3";
    fill_table(0);
    wait_cfg = 4;
    push_entries(4, 1'b0);
    push_done(1'b0, 9'd0, 1'b1, 28);
    applyStimulus(1'b0);
    wait_access(3, 200);
    stop_i = 1'b1;
    @(negedge p_clk);
    stop_i = 1'b0;
    wait_done(200);
    wait_cfg = 0;
    checkOutput("stopped_o held in idle", 32'(stopped_o), 32'h1);

    cur_test = "start_while_busy";
    fill_table(1);
    push_entries(N, 1'b0);
    push_done(1'b0, 9'd0, 1'b0, 1026);
    applyStimulus(1'b0);
    wait_access(2, 100);
    start_i = 1'b1;
    verify_en_i = 1'b1;
    @(negedge p_clk);
    start_i = 1'b0;
    wait_access(100, 1000);
    start_i = 1'b1;
    @(negedge p_clk);
    start_i = 1'b0;
    verify_en_i = 1'b0;
    wait_done(3000);

    cur_test = "reset_entry10";
    fill_table(0);
    wait_cfg = 4;
    push_entries(10, 1'b0);
    applyStimulus(1'b0);
    wait_access(10, 300);
    p_rst = 1'b1;
    @(negedge p_clk);
    p_rst = 1'b0;
    checkOutput("psel after reset", 32'(apb_reg_psel), 32'h0);
    checkOutput("penable after reset", 32'(apb_reg_penable), 32'h0);
    checkOutput("busy_o after reset", 32'(busy_o), 32'h0);
    checkOutput("tbl_rd_o after reset", 32'(tbl_rd_o), 32'h0);
    checkOutput("transfers before reset", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    wait_cfg = 0;

    cur_test = "restart_after_reset";
    fill_table(2);
    push_entries(N, 1'b0);
    push_done(1'b0, 9'd0, 1'b0, 1026);
    applyStimulus(1'b0);
    wait_done(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/apb_reg_init_seq.md
APB_REG_INIT_SEQ -- requirements
Module: apb_reg_init_seq

Interface
REQ-001 SHALL have parameters: NO_APB_REGS=342 (table entries); APB_ADDR_WIDTH=32; APB_DATA_WIDTH=32; REG_DATA_WIDTH=16 (table word width); BASE_ADDR=32'h0013_0000 (first target address); ADDR_STRIDE=4 (bytes per register).
REQ-002 SHALL have one clock and a synchronous, active-high reset: p_clk  in  1  clock, all state changes on rising edge; p_rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: start_i  in  1  pulse that begins a load sequence; stop_i  in  1  request to end the sequence early; verify_en_i  in  1  enables write-then-readback per entry, sampled on accepted start.
REQ-004 SHALL have table ports: tbl_rd_o  out  1  table read strobe; tbl_idx_o  out  $clog2(NO_APB_REGS)  entry index; tbl_data_i  in  REG_DATA_WIDTH  entry data, valid exactly one cycle after tbl_rd_o.
REQ-005 SHALL have APB master ports: apb_reg_paddr  out  APB_ADDR_WIDTH; apb_reg_pprot  out  3; apb_reg_psel  out  1; apb_reg_penable  out  1; apb_reg_pwrite  out  1; apb_reg_pwdata  out  APB_DATA_WIDTH; apb_reg_pstrb  out  APB_DATA_WIDTH/8; apb_reg_pready  in  1; apb_reg_prdata  in  APB_DATA_WIDTH; apb_reg_pslverr  in  1.
REQ-006 SHALL have status ports: busy_o  out  1  sequence active; done_o  out  1  one-cycle completion pulse; stopped_o  out  1  last sequence ended by stop_i; err_o  out  1  sticky error; err_idx_o  out  $clog2(NO_APB_REGS)  index of first failing entry.

Function
REQ-007 SHALL implement states IDLE, FETCH, WR_SETUP, WR_ACCESS, RB_SETUP, RB_ACCESS, DONE.
REQ-008 SHALL, in IDLE with start_i=1, clear err_o, err_idx_o, stopped_o, set index to 0, latch verify_en_i, and enter FETCH next cycle.
REQ-009 SHALL ignore start_i in any state other than IDLE.
REQ-010 SHALL assert tbl_rd_o for exactly one cycle in FETCH with tbl_idx_o = current index, then enter WR_SETUP.
REQ-011 SHALL capture tbl_data_i on entry to WR_SETUP and hold it for the entry's write and readback.
REQ-012 SHALL drive in WR_SETUP: psel=1, penable=0, pwrite=1, paddr=BASE_ADDR+index*ADDR_STRIDE (modulo 2^APB_ADDR_WIDTH), pwdata=data zero-extended, pstrb all ones, pprot=3'b000; then enter WR_ACCESS.
REQ-013 SHALL in WR_ACCESS hold all WR_SETUP values with penable=1 until pready=1; wait states are unbounded.
REQ-014 SHALL on WR_ACCESS completion enter RB_SETUP if verify latched, else end the entry.
REQ-015 SHALL in RB_SETUP/RB_ACCESS perform an APB read at the same paddr (pwrite=0, pstrb=0) with the same setup/access rules.
REQ-016 SHALL on RB_ACCESS completion flag a mismatch if prdata[REG_DATA_WIDTH-1:0] differs from held data; upper bits ignored.
REQ-017 SHALL treat pslverr=1 in the completing ACCESS cycle (write or read) or a readback mismatch as an entry error: set err_o; load err_idx_o only if err_o was 0; continue the sequence.
REQ-018 SHALL at end of entry enter DONE if index=NO_APB_REGS-1 or a stop request is pending, else increment index and enter FETCH.
REQ-019 SHALL latch stop_i asserted in any non-IDLE state as a pending stop; the current entry's write (and readback) always completes; stopped_o set on entering DONE via stop.
REQ-020 SHALL assert done_o for exactly the one DONE cycle, then return to IDLE.
REQ-021 SHALL drive busy_o=1 in every state except IDLE.
REQ-022 SHALL drive psel=0, penable=0 in IDLE, FETCH, DONE; paddr/pwdata are don't-care there but SHALL not toggle.
REQ-023 SHALL with pready tied high complete each entry in 3 cycles (5 with verify); a full 342-entry write-only load takes 1026 cycles from FETCH of entry 0 to done_o.

Reset
REQ-024 SHALL on p_rst=1 at a clock edge enter IDLE and clear all outputs and flags to 0, including mid-transfer; outstanding APB transfer is abandoned.
REQ-025 SHALL give p_rst priority over start_i and stop_i in the same cycle.

Verification
REQ-026 Full load, pready=1, verify off, table[i]=i -> 342 writes, paddr 0x0013_0000..0x0013_0554, pwdata=i, done_o at cycle 1026, err_o=0.
REQ-027 Verify on, slave returns stored data except entry 5 reads 0xFFFF -> err_o=1, err_idx_o=5, all 342 entries still written.
REQ-028 pslverr on write of entries 7 and 9 -> err_idx_o=7, err_o=1, sequence completes.
REQ-029 stop_i pulse during WR_ACCESS of entry 3 with pready low 4 cycles -> entry 3 completes, done_o next, stopped_o=1, no entry-4 access.
REQ-030 p_rst during WR_ACCESS of entry 10 -> next cycle psel=0, busy_o=0; new start_i restarts at index 0.
REQ-031 start_i pulsed while busy -> ignored, index sequence unchanged.
